cory_delay_sink: RTL

CORY_DELAY_SINK -- requirements
Module: cory_delay_sink

---
 rtl/cory_delay_sink.sv | 106 ++++++++++
 1 files changed

// File: rtl/cory_delay_sink.sv
// rtl/cory_delay_sink.sv - credit-gated return buffer for a fixed-latency pipe.
// Optional launch/return checker enabled by CORY_DELAY_SINK_CHECK_EN.
module cory_delay_sink #(
  parameter int N     = 8,
  parameter int D     = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic                         o_launch_ok,
  input  logic                         i_launch,
  input  logic                         i_a_valid,
  input  logic [N-1:0]                 i_a,
  output logic                         o_z_valid,
  output logic [N-1:0]                 o_z,
  input  logic                         i_z_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_cnt,
  output logic                         o_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] in_flight;
  logic [CW:0]   used;
  logic          accept;
  logic          pop;
  logic          full;
  logic          push;
  logic          dec;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both entries still in the pipe and entries already stored.
  assign used        = {1'b0, in_flight} + {1'b0, cnt};
  assign o_launch_ok = (used < (CW+1)'(DEPTH));
  assign accept      = i_launch && o_launch_ok;
  assign full        = (cnt == CW'(DEPTH));
  assign pop         = o_z_valid && i_z_ready;
  assign push        = i_a_valid && (!full || pop);
  // Unmatched returns never drive the in-flight count below zero.
  assign dec         = i_a_valid && (in_flight != '0);

  assign o_z_valid = (cnt != '0);
  assign o_z       = mem[rd_ptr];
  assign o_cnt     = cnt;

  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem[wr_ptr] <= i_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      in_flight <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      case ({accept, dec})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

`ifdef CORY_DELAY_SINK_CHECK_EN
  logic [D-1:0] chk_sr;
  logic         err_q;
  logic         overflow;

  assign overflow = i_a_valid && full && !pop;
  assign o_err    = err_q;

  // Bit D-1 holds the accept decision made exactly D cycles ago.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chk_sr <= '0;
      err_q  <= 1'b0;
    end else begin
      chk_sr <= D'({chk_sr, accept});
      if ((i_a_valid != chk_sr[D-1]) || overflow) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule
